// File: rtl/sr_ssp_stack_seq_pkg.sv
// Shared widths, SR index of the shadow stack pointer, op and state encodings
// for the shadow-stack sequencer.
package sr_ssp_stack_seq_pkg;

   localparam int unsigned ADDR_W_DFLT   = 48;
   localparam int unsigned SR_IDX_W_DFLT = 5;
   localparam int unsigned SR_IDX_SSP    = 2;
   localparam logic [47:0] SSP_RESET     = 48'h000000000FFF;

   typedef enum logic {
      OpPush = 1'b0,
      OpPop  = 1'b1
   } stack_op_e;

   typedef enum logic [2:0] {
      StIdle,
      StRdSsp,
      StMemReq,
      StMemWait,
      StWb,
      StDone
   } seq_state_e;

endpackage

// File: rtl/sr_ssp_stack_seq_if.sv
// Request/response, SR-file and data-memory signals of the shadow-stack sequencer.
// master is the sequencer side, slave is the surrounding pipeline/SR file/memory.
interface sr_ssp_stack_seq_if #(
   parameter int unsigned ADDR_W   = 48,
   parameter int unsigned SR_IDX_W = 5
);
   logic                iw_req_valid;
   logic                iw_req_op;
   logic [ADDR_W-1:0]   iw_req_data;
   logic                ow_req_ready;
   logic                ow_rsp_valid;
   logic [ADDR_W-1:0]   ow_rsp_data;
   logic                ow_rsp_err;
   logic [SR_IDX_W-1:0] ow_sr_read_addr;
   logic [ADDR_W-1:0]   iw_sr_read_data;
   logic [SR_IDX_W-1:0] ow_sr_write_addr;
   logic [ADDR_W-1:0]   ow_sr_write_data;
   logic                ow_sr_write_enable;
   logic                iw_sr_wb_busy;
   logic                ow_mem_valid;
   logic                ow_mem_we;
   logic [ADDR_W-1:0]   ow_mem_addr;
   logic [ADDR_W-1:0]   ow_mem_wdata;
   logic                iw_mem_ready;
   logic                iw_mem_rdata_valid;
   logic [ADDR_W-1:0]   iw_mem_rdata;

   modport master (
      input  iw_req_valid, iw_req_op, iw_req_data, iw_sr_read_data, iw_sr_wb_busy,
             iw_mem_ready, iw_mem_rdata_valid, iw_mem_rdata,
      output ow_req_ready, ow_rsp_valid, ow_rsp_data, ow_rsp_err, ow_sr_read_addr,
             ow_sr_write_addr, ow_sr_write_data, ow_sr_write_enable, ow_mem_valid,
             ow_mem_we, ow_mem_addr, ow_mem_wdata
   );

   modport slave (
      output iw_req_valid, iw_req_op, iw_req_data, iw_sr_read_data, iw_sr_wb_busy,
             iw_mem_ready, iw_mem_rdata_valid, iw_mem_rdata,
      input  ow_req_ready, ow_rsp_valid, ow_rsp_data, ow_rsp_err, ow_sr_read_addr,
             ow_sr_write_addr, ow_sr_write_data, ow_sr_write_enable, ow_mem_valid,
             ow_mem_we, ow_mem_addr, ow_mem_wdata
   );
endinterface

// File: rtl/sr_ssp_stack_seq.sv
// Push/pop sequencer on the shadow stack: read SSP from the SR file, bounds-check,
// one memory word access, write the updated SSP back, pulse completion.
module sr_ssp_stack_seq
   import sr_ssp_stack_seq_pkg::*;
#(
   parameter int unsigned       ADDR_W    = ADDR_W_DFLT,
   parameter int unsigned       SR_IDX_W  = SR_IDX_W_DFLT,
   parameter int unsigned       SSP_IDX   = SR_IDX_SSP,
   parameter logic [ADDR_W-1:0] STACK_TOP = ADDR_W'(SSP_RESET)
) (
   input logic                iw_clk,
   input logic                iw_rst,
   sr_ssp_stack_seq_if.master bus
);

   localparam logic [ADDR_W-1:0] One = ADDR_W'(1);

   seq_state_e        state_q;
   stack_op_e         op_q;
   logic [ADDR_W-1:0] data_q;
   logic [ADDR_W-1:0] ssp_q;
   logic [ADDR_W-1:0] rdata_q;
   logic              mem_valid_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [ADDR_W-1:0] mem_wdata_q;
   logic              rsp_valid_q;
   logic              rsp_err_q;
   logic [ADDR_W-1:0] rsp_data_q;

   logic [ADDR_W-1:0] ssp_rd;
   logic              bounds_err;

   // Empty-descending stack: SSP==0 means full, SSP==STACK_TOP means empty.
   assign ssp_rd     = bus.iw_sr_read_data;
   assign bounds_err = (op_q == OpPush) ? (ssp_rd == '0) : (ssp_rd == STACK_TOP);

   assign bus.ow_req_ready       = (state_q == StIdle);
   assign bus.ow_rsp_valid       = rsp_valid_q;
   assign bus.ow_rsp_data        = rsp_data_q;
   assign bus.ow_rsp_err         = rsp_err_q;
   assign bus.ow_sr_read_addr    = SR_IDX_W'(SSP_IDX);
   assign bus.ow_sr_write_addr   = SR_IDX_W'(SSP_IDX);
   assign bus.ow_sr_write_data   = (op_q == OpPush) ? (ssp_q - One) : (ssp_q + One);
   assign bus.ow_sr_write_enable = (state_q == StWb) && !bus.iw_sr_wb_busy;
   assign bus.ow_mem_valid       = mem_valid_q;
   assign bus.ow_mem_we          = mem_we_q;
   assign bus.ow_mem_addr        = mem_addr_q;
   assign bus.ow_mem_wdata       = mem_wdata_q;

   always_ff @(posedge iw_clk) begin
      if (iw_rst) begin
         state_q     <= StIdle;
         op_q        <= OpPush;
         data_q      <= '0;
         ssp_q       <= '0;
         rdata_q     <= '0;
         mem_valid_q <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_data_q  <= '0;
         unique case (state_q)
            StIdle: begin
               if (bus.iw_req_valid) begin
                  op_q    <= stack_op_e'(bus.iw_req_op);
                  data_q  <= bus.iw_req_data;
                  state_q <= StRdSsp;
               end
            end
            StRdSsp: begin
               ssp_q <= ssp_rd;
               if (bounds_err) begin
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                  state_q     <= StDone;
               end else begin
                  mem_valid_q <= 1'b1;
                  mem_we_q    <= (op_q == OpPush);
                  mem_addr_q  <= (op_q == OpPush) ? ssp_rd : (ssp_rd + One);
                  mem_wdata_q <= data_q;
                  state_q     <= StMemReq;
               end
            end
            StMemReq: begin
               if (bus.iw_mem_ready) begin
                  mem_valid_q <= 1'b0;
                  mem_we_q    <= 1'b0;
                  state_q     <= (op_q == OpPush) ? StWb : StMemWait;
               end
            end
            StMemWait: begin
               if (bus.iw_mem_rdata_valid) begin
                  rdata_q <= bus.iw_mem_rdata;
                  state_q <= StWb;
               end
            end
            StWb: begin
               // The SR write lands in the cycle writeback leaves the port free.
               if (!bus.iw_sr_wb_busy) begin
                  rsp_valid_q <= 1'b1;
                  rsp_data_q  <= (op_q == OpPop) ? rdata_q : '0;
                  state_q     <= StDone;
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule
